// File: rtl/ulbf_data_seq_pkg.sv
// Shared types and constants for the ulbf_data run sequencer.
package ulbf_data_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RESET  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_FINISH = 3'd5
  } seq_state_e;

  localparam int RUN_COUNT_W = 16;
  localparam int TIMEOUT_W   = 32;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 12;
  localparam int DEF_ADDR_W = 16;

endpackage

// File: rtl/ulbf_data_seq_tmr.sv
// Loadable down-counter with a zero flag; holds at zero once expired.
module ulbf_data_seq_tmr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/ulbf_data_seq_ctrl.sv
// Run sequencer for the ulbf_data playback channels: shadow config, channel
// reset/settle, go/done handshake and looping. Optional ULBF_SEQ_TIMEOUT_EN.
module ulbf_data_seq_ctrl
  import ulbf_data_seq_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 6
) (
  input  logic                   m_axis_clk,
  input  logic                   m_axis_rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [CNT_W-1:0]       cfg_block_size,
  input  logic [CNT_W-1:0]       cfg_niter,
  input  logic [ADDR_W-1:0]      cfg_rollover_addr,
  input  logic [NUM_CH-1:0]      cfg_ch_en,
  input  logic                   cfg_loop,
  input  logic [NUM_CH-1:0]      ch_done,
`ifdef ULBF_SEQ_TIMEOUT_EN
  input  logic [TIMEOUT_W-1:0]   cfg_timeout,
  output logic                   err_timeout,
`endif
  output logic [NUM_CH-1:0]      ch_go,
  output logic                   ch_rst,
  output logic [CNT_W-1:0]       block_size,
  output logic [CNT_W-1:0]       niter,
  output logic [ADDR_W-1:0]      rollover_addr,
  output logic                   busy,
  output logic                   run_done,
  output logic [RUN_COUNT_W-1:0] run_count,
  output logic                   err_cfg
);

  localparam int DWELL_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int DWELL_W   = $clog2(DWELL_MAX + 1);
  localparam logic [DWELL_W-1:0] RST_LD    = DWELL_W'(RST_CYCLES - 1);
  localparam logic [DWELL_W-1:0] SETTLE_LD = DWELL_W'(SETTLE_CYCLES - 1);

  seq_state_e         state_q, state_d;
  logic [NUM_CH-1:0]  ch_en_q;
  logic               latch_cfg, err_set, err_clr;
  logic               dwell_load, dwell_dec, dwell_zero;
  logic [DWELL_W-1:0] dwell_val;
  logic               cfg_bad, en_done_any, en_done_all;

  assign cfg_bad     = (cfg_block_size == '0) || (cfg_rollover_addr == '0) || (cfg_ch_en == '0);
  assign en_done_any = ((ch_done & ch_en_q) != '0);
  assign en_done_all = ((ch_done & ch_en_q) == ch_en_q);

`ifdef ULBF_SEQ_TIMEOUT_EN
  logic tmo_load, tmo_zero, tmo_hit, tmo_set, tmo_clr;

  assign tmo_load = (state_q == ST_SETTLE) && (state_d == ST_RUN);
  assign tmo_hit  = (cfg_timeout != '0) && tmo_zero;

  ulbf_data_seq_tmr #(.WIDTH(TIMEOUT_W)) u_tmo_tmr (
    .clk      (m_axis_clk),
    .rst_n    (m_axis_rst_n),
    .load     (tmo_load),
    .load_val (cfg_timeout - 32'd1),
    .dec      (state_q == ST_RUN),
    .zero     (tmo_zero)
  );
`endif

  ulbf_data_seq_tmr #(.WIDTH(DWELL_W)) u_dwell_tmr (
    .clk      (m_axis_clk),
    .rst_n    (m_axis_rst_n),
    .load     (dwell_load),
    .load_val (dwell_val),
    .dec      (dwell_dec),
    .zero     (dwell_zero)
  );

  always_comb begin
    state_d    = state_q;
    latch_cfg  = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    dwell_load = 1'b0;
    dwell_val  = RST_LD;
    dwell_dec  = 1'b0;
`ifdef ULBF_SEQ_TIMEOUT_EN
    tmo_set    = 1'b0;
    tmo_clr    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_LOAD;
`ifdef ULBF_SEQ_TIMEOUT_EN
          tmo_clr = 1'b1;
`endif
        end
      end
      ST_LOAD: begin
        latch_cfg = 1'b1;
        if (cfg_bad) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          err_clr    = 1'b1;
          dwell_load = 1'b1;
          state_d    = ST_RESET;
        end
      end
      ST_RESET: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (dwell_zero) begin
          dwell_load = 1'b1;
          dwell_val  = SETTLE_LD;
          state_d    = ST_SETTLE;
        end else begin
          dwell_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        // Stale done from the previous run must clear before go is raised.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (dwell_zero && !en_done_any) begin
          state_d = ST_RUN;
        end else begin
          dwell_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (en_done_all) begin
          state_d = ST_FINISH;
        end
`ifdef ULBF_SEQ_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_set = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end
      ST_FINISH: begin
        if (cfg_loop && !stop) begin
          dwell_load = 1'b1;
          state_d    = ST_RESET;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
    if (!m_axis_rst_n) begin
      state_q       <= ST_IDLE;
      ch_en_q       <= '0;
      ch_go         <= '0;
      ch_rst        <= 1'b1;
      block_size    <= '0;
      niter         <= '0;
      rollover_addr <= '0;
      busy          <= 1'b0;
      run_done      <= 1'b0;
      run_count     <= '0;
      err_cfg       <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_go    <= (state_d == ST_RUN) ? ch_en_q : '0;
      ch_rst   <= (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_RESET);
      busy     <= (state_d != ST_IDLE);
      run_done <= (state_d == ST_FINISH);
      if ((state_d == ST_FINISH) && (run_count != '1)) begin
        run_count <= run_count + 1'b1;
      end
      if (latch_cfg) begin
        block_size    <= cfg_block_size;
        niter         <= cfg_niter;
        rollover_addr <= cfg_rollover_addr;
        ch_en_q       <= cfg_ch_en;
      end
      if (err_set) begin
        err_cfg <= 1'b1;
      end else if (err_clr) begin
        err_cfg <= 1'b0;
      end
    end
  end

`ifdef ULBF_SEQ_TIMEOUT_EN
  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
    if (!m_axis_rst_n) begin
      err_timeout <= 1'b0;
    end else if (tmo_set) begin
      err_timeout <= 1'b1;
    end else if (tmo_clr) begin
      err_timeout <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ulbf_data_seq_ctrl.sv
// Self-checking bench for ulbf_data_seq_ctrl with a behavioural channel model.
module tb_ulbf_data_seq_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 12;
  localparam int ADDR_W = 16;

  logic              m_axis_clk = 1'b0;
  logic              m_axis_rst_n;
  logic              start, stop, cfg_loop;
  logic [CNT_W-1:0]  cfg_block_size, cfg_niter;
  logic [ADDR_W-1:0] cfg_rollover_addr;
  logic [NUM_CH-1:0] cfg_ch_en, ch_done;
  logic [NUM_CH-1:0] ch_go;
  logic              ch_rst, busy, run_done, err_cfg;
  logic [CNT_W-1:0]  block_size, niter;
  logic [ADDR_W-1:0] rollover_addr;
  logic [15:0]       run_count;
`ifdef ULBF_SEQ_TIMEOUT_EN
  logic [31:0]       cfg_timeout;
  logic              err_timeout;
`endif

  always #5 m_axis_clk = ~m_axis_clk;

  ulbf_data_seq_ctrl dut (
    .m_axis_clk        (m_axis_clk),
    .m_axis_rst_n      (m_axis_rst_n),
    .start             (start),
    .stop              (stop),
    .cfg_block_size    (cfg_block_size),
    .cfg_niter         (cfg_niter),
    .cfg_rollover_addr (cfg_rollover_addr),
    .cfg_ch_en         (cfg_ch_en),
    .cfg_loop          (cfg_loop),
    .ch_done           (ch_done),
`ifdef ULBF_SEQ_TIMEOUT_EN
    .cfg_timeout       (cfg_timeout),
    .err_timeout       (err_timeout),
`endif
    .ch_go             (ch_go),
    .ch_rst            (ch_rst),
    .block_size        (block_size),
    .niter             (niter),
    .rollover_addr     (rollover_addr),
    .busy              (busy),
    .run_done          (run_done),
    .run_count         (run_count),
    .err_cfg           (err_cfg)
  );

  typedef struct {
    logic [CNT_W-1:0]  bs;
    logic [CNT_W-1:0]  ni;
    logic [ADDR_W-1:0] ra;
    logic [NUM_CH-1:0] en;
    bit                bad;
  } vec_t;

  typedef struct {
    bit                bad;
    logic [CNT_W-1:0]  bs;
    logic [CNT_W-1:0]  ni;
    logic [ADDR_W-1:0] ra;
    logic [NUM_CH-1:0] en;
    logic [15:0]       rc;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Channel model state: done rises DONE_DLY go-cycles after go, clears in reset.
  int                go_cnt [NUM_CH];
  int                done_dly = 40;
  logic [NUM_CH-1:0] done_mask = '1;
  bit                stale_mode = 0;
  int                stale_left = 0;
  int                rst_cnt = 0, last_rst = 0;
  int                settle_cnt = 0, last_settle = 0;
  bit                settle_on = 0;
  int                rd_cnt = 0;
  logic [NUM_CH-1:0] go_seen = '0;
  logic [15:0]       exp_rc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge m_axis_clk);
    #1;
    if (run_done) rd_cnt++;
    go_seen |= ch_go;
    if (ch_rst) begin
      rst_cnt++;
      settle_on  = 1;
      settle_cnt = 0;
      stale_left = 10;
      for (int i = 0; i < NUM_CH; i++) go_cnt[i] = 0;
      if (!stale_mode) ch_done = '0;
    end else begin
      if (rst_cnt > 0) begin
        last_rst = rst_cnt;
        rst_cnt  = 0;
      end
      if (settle_on) begin
        if (ch_go == '0) settle_cnt++;
        else begin
          last_settle = settle_cnt;
          settle_on   = 0;
        end
      end
      if (stale_left > 0) begin
        stale_left--;
        if (stale_left == 0) ch_done = '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_go[i]) begin
          go_cnt[i]++;
          if (go_cnt[i] >= done_dly && done_mask[i]) ch_done[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({name, " idle"}, busy, 0);
  endtask

  task automatic wait_go(input string name, input int budget);
    int n = 0;
    while (ch_go == '0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, " go"}, ch_go, cfg_ch_en);
  endtask

  task automatic set_cfg(input vec_t v);
    cfg_block_size    = v.bs;
    cfg_niter         = v.ni;
    cfg_rollover_addr = v.ra;
    cfg_ch_en         = v.en;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    exp_t sb [$];
    exp_t e;
    logic err_at2;
    int   n;

    vt[0] = '{bs: 12'd8,  ni: 12'd2, ra: 16'd64,  en: 4'b0011, bad: 0};
    vt[1] = '{bs: 12'd0,  ni: 12'd2, ra: 16'd64,  en: 4'b0011, bad: 1};
    vt[2] = '{bs: 12'd16, ni: 12'd1, ra: 16'd128, en: 4'b0101, bad: 0};
    vt[3] = '{bs: 12'd5,  ni: 12'd1, ra: 16'd0,   en: 4'b0001, bad: 1};
    vt[4] = '{bs: 12'd5,  ni: 12'd1, ra: 16'd9,   en: 4'b0000, bad: 1};
    vt[5] = '{bs: 12'd4,  ni: 12'd3, ra: 16'd1,   en: 4'b1111, bad: 0};

    m_axis_rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cfg_loop = 1'b0;
    ch_done = '0;
    set_cfg(vt[0]);
`ifdef ULBF_SEQ_TIMEOUT_EN
    cfg_timeout = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) go_cnt[i] = 0;
    repeat (3) tick();
    chk("reset ch_rst", ch_rst, 1);
    m_axis_rst_n = 1'b1;
    repeat (2) tick();
    chk("reset ch_go", ch_go, 0);
    chk("reset ch_rst idle", ch_rst, 1);
    chk("reset busy", busy, 0);
    chk("reset run_done", run_done, 0);
    chk("reset run_count", run_count, 0);
    chk("reset err_cfg", err_cfg, 0);
    chk("reset block_size", block_size, 0);
    chk("reset rollover", rollover_addr, 0);

    // Table-driven single runs with a scoreboard of expected outcomes.
    for (int v = 0; v < 6; v++) begin
      set_cfg(vt[v]);
      rd_cnt  = 0;
      go_seen = '0;
      if (!vt[v].bad) exp_rc++;
      sb.push_back('{bad: vt[v].bad, bs: vt[v].bs, ni: vt[v].ni, ra: vt[v].ra,
                     en: (vt[v].bad ? 4'b0000 : vt[v].en), rc: exp_rc});
      pulse_start();
      tick();
      err_at2 = err_cfg;
      wait_idle($sformatf("vec%0d", v), 2000);
      e = sb.pop_front();
      chk($sformatf("vec%0d err_cfg timing", v), err_at2, e.bad);
      chk($sformatf("vec%0d err_cfg", v), err_cfg, e.bad);
      chk($sformatf("vec%0d go_seen", v), go_seen, e.en);
      chk($sformatf("vec%0d run_done pulses", v), rd_cnt, e.bad ? 0 : 1);
      chk($sformatf("vec%0d run_count", v), run_count, e.rc);
      chk($sformatf("vec%0d block_size", v), block_size, e.bs);
      chk($sformatf("vec%0d niter", v), niter, e.ni);
      chk($sformatf("vec%0d rollover", v), rollover_addr, e.ra);
      chk($sformatf("vec%0d ch_rst", v), ch_rst, 1);
      if (!e.bad) chk($sformatf("vec%0d settle gap", v), last_settle, 6);
    end

    // Looping with stale done held across the re-arm gap.
    set_cfg(vt[0]);
    cfg_loop   = 1'b1;
    stale_mode = 1;
    rd_cnt     = 0;
    pulse_start();
    n = 0;
    while (rd_cnt < 3 && n < 3000) begin
      tick();
      n++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    exp_rc += 16'd3;
    chk("loop run_done pulses", rd_cnt, 3);
    chk("loop run_count", run_count, exp_rc);
    chk("loop busy", busy, 0);
    chk("loop ch_rst", ch_rst, 1);
    chk("loop reset gap", last_rst, 8);
    chk("loop stale settle gap", last_settle, 10);
    cfg_loop   = 1'b0;
    stale_mode = 0;
    tick();

    // Free-running run aborted by stop; start inside a run is ignored.
    cfg_niter = '0;
    done_mask = '0;
    rd_cnt    = 0;
    pulse_start();
    wait_go("stop", 200);
    repeat (50) tick();
    pulse_start();
    repeat (49) tick();
    chk("stop go before", ch_go, 4'b0011);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop ch_go", ch_go, 0);
    chk("stop run_done", rd_cnt, 0);
    chk("stop run_count", run_count, exp_rc);
    chk("stop ch_rst", ch_rst, 1);
    chk("stop busy", busy, 0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("start+stop busy", busy, 0);
    tick();
    chk("start+stop busy later", busy, 0);

    // Partial done keeps RUN until the last enabled channel reports.
    set_cfg(vt[5]);
    done_mask = 4'b0111;
    rd_cnt    = 0;
    pulse_start();
    wait_go("partial", 200);
    repeat (60) tick();
    chk("partial go held", ch_go, 4'b1111);
    chk("partial busy", busy, 1);
    chk("partial no run_done", rd_cnt, 0);
    done_mask = 4'b1111;
    wait_idle("partial", 200);
    exp_rc++;
    chk("partial run_done", rd_cnt, 1);
    chk("partial run_count", run_count, exp_rc);

    // Asynchronous reset in SETTLE.
    pulse_start();
    n = 0;
    while (!(busy && !ch_rst && ch_go == '0) && n < 100) begin
      tick();
      n++;
    end
    chk("areset reached settle", ch_rst, 0);
    #2;
    m_axis_rst_n = 1'b0;
    #1;
    chk("areset ch_rst", ch_rst, 1);
    chk("areset busy", busy, 0);
    chk("areset ch_go", ch_go, 0);
    chk("areset run_count", run_count, 0);
    chk("areset block_size", block_size, 0);
    #2;
    m_axis_rst_n = 1'b1;
    exp_rc = '0;
    repeat (2) tick();
    chk("areset idle busy", busy, 0);

`ifdef ULBF_SEQ_TIMEOUT_EN
    // Timeout with no done ever arriving.
    set_cfg(vt[0]);
    done_mask   = '0;
    cfg_timeout = 32'd50;
    rd_cnt      = 0;
    pulse_start();
    wait_go("timeout", 200);
    n = 0;
    while (ch_go != '0 && n < 500) begin
      n++;
      tick();
    end
    chk("timeout run length", n, 50);
    chk("timeout err_timeout", err_timeout, 1);
    chk("timeout busy", busy, 0);
    chk("timeout run_done", rd_cnt, 0);
    chk("timeout run_count", run_count, exp_rc);
    done_mask   = '1;
    cfg_timeout = '0;
    pulse_start();
    tick();
    chk("timeout cleared", err_timeout, 0);
    wait_idle("timeout clear run", 2000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ulbf_data_seq_ctrl.md
Name: ulbf_data_seq_ctrl

Overview:
Run sequencer for NUM_CH ulbf_data RAM-to-AXIS playback channels. It latches a shadow copy of the run configuration (block_size, niter, rollover_addr), resets the channels, and raises their go inputs. It then waits for every enabled channel's done and optionally re-arms for continuous looping. It sits between the AXI-Lite control registers and the channel datapaths, in the m_axis_clk domain.

Parameters:
NUM_CH, 4, number of playback channels sequenced.
CNT_W, 12, width of block_size and niter.
ADDR_W, 16, width of rollover_addr.
RST_CYCLES, 8, cycles ch_rst is held high per run (min 2).
SETTLE_CYCLES, 6, minimum cycles after ch_rst release before ch_go rises; covers the channel's 4-stage go/done pipelines.

Ports:
m_axis_clk  in  1  clock.
m_axis_rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse; begins a run from IDLE.
stop  in  1  level; requests graceful abort or loop exit.
cfg_block_size  in  CNT_W  samples per tlast block.
cfg_niter  in  CNT_W  blocks per run; 0 = free-running.
cfg_rollover_addr  in  ADDR_W  RAM read wrap point.
cfg_ch_en  in  NUM_CH  channel enable mask.
cfg_loop  in  1  1 = re-arm automatically after each completed run.
ch_done  in  NUM_CH  per-channel done, already pipelined by the channel.
ch_go  out  NUM_CH  per-channel go level.
ch_rst  out  1  active-high synchronous reset to channel datapaths.
block_size  out  CNT_W  shadow config to channels.
niter  out  CNT_W  shadow config.
rollover_addr  out  ADDR_W  shadow config.
busy  out  1  high in any state except IDLE.
run_done  out  1  one-cycle pulse per completed run.
run_count  out  16  completed runs since reset; saturates at 0xFFFF.
err_cfg  out  1  sticky; set on invalid configuration; cleared by next accepted start.

Behaviour:
- Reset values: ch_go=0, ch_rst=1, shadow regs=0, busy=0, run_done=0, run_count=0, err_cfg=0, state=IDLE. All outputs are registered.
- States: IDLE, LOAD, RESET, SETTLE, RUN, FINISH.
- IDLE: ch_rst=1. On start, go to LOAD.
- LOAD (1 cycle): latch cfg_* into the shadow regs and a ch_en shadow.
  - If block_size==0, rollover_addr==0 or ch_en==0: set err_cfg and return to IDLE.
  - Otherwise clear err_cfg and go to RESET.
- RESET: ch_rst=1 for exactly RST_CYCLES cycles, then go to SETTLE.
- SETTLE: ch_rst=0. Count SETTLE_CYCLES. Advance to RUN only when the count has expired AND (ch_done & ch_en)==0. This ignores stale done from the previous run.
- RUN: ch_go = ch_en shadow; disabled channels keep go=0.
  - When (ch_done & ch_en)==ch_en, go to FINISH.
  - With niter==0, done never arrives; only stop exits RUN.
- FINISH (1 cycle): ch_go=0, run_done=1, run_count++ (saturating).
  - If cfg_loop && !stop, go to RESET. Shadow config is NOT reloaded; reload requires a new start from IDLE.
  - Otherwise go to IDLE.
- stop in RESET, SETTLE or RUN: drop ch_go next cycle, go to IDLE without run_done and without incrementing run_count. ch_rst reasserts in IDLE.
- start outside IDLE is ignored.
- start and stop in the same cycle in IDLE: stop wins, stay IDLE.
- Partial done (subset of enabled channels): remain in RUN.
- Asynchronous reset mid-run: all outputs return to reset values immediately.

Optional Feature:
ULBF_SEQ_TIMEOUT_EN.
- When defined: adds input cfg_timeout[31:0] and sticky output err_timeout.
  - A 32-bit cycle counter runs in RUN.
  - If it reaches cfg_timeout (nonzero) before all done, set err_timeout and abort to IDLE exactly like stop.
  - err_timeout clears on the next accepted start.
- When undefined: neither port exists and there is no counter.

Decomposition:
- Package ulbf_data_seq_pkg holds:
  - state enum (3-bit encoding);
  - RUN_COUNT_W=16;
  - TIMEOUT_W=32;
  - default NUM_CH/CNT_W/ADDR_W constants.
- One sub-module: ulbf_data_seq_tmr, a loadable down-counter with a zero flag. It is instanced for the RESET/SETTLE dwell and for the optional timeout.

Test Plan:
- Basic run: ch_en=4'b0011, block_size=8, niter=2, start; model raises ch_done[1:0] 40 cycles after go. Expect ch_rst high 8 cycles, go rising ≥6 cycles after ch_rst falls, one run_done pulse, run_count=1, return to IDLE.
- Invalid config: block_size=0, start. Expect err_cfg=1 one cycle after LOAD, ch_go never asserted, busy back to 0; next valid start clears err_cfg.
- Loop: cfg_loop=1, 3 runs, then stop asserted. Expect run_count=3, a reset/settle gap between runs, stale ch_done held high for 10 cycles after ch_rst blocking RUN entry.
- Stop mid-RUN with niter=0: after 100 cycles assert stop. Expect ch_go=0 next cycle, no run_done, run_count unchanged, ch_rst=1.
- Partial done: ch_en=4'b1111, only ch_done[2:0] high. Expect the block stays in RUN; FINISH only when ch_done[3] rises.
- Async reset pulse during SETTLE and, with ULBF_SEQ_TIMEOUT_EN, cfg_timeout=50 with no done. Expect immediate reset values; err_timeout=1 at cycle 50 of RUN.
